// File: rtl/axi4_wr_arbiter_if.sv
// AXI4 write-channel bundle (AW, W, B) shared by both source masters and the
// downstream port; the downstream instance is built with IW+1 ID bits.
interface axi4_wr_arbiter_if #(
    parameter int DW = 512,
    parameter int AW = 64,
    parameter int IW = 4
);
    logic [AW-1:0]   awaddr;
    logic            awuser;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [IW-1:0]   awid;
    logic [1:0]      awburst;
    logic            awlock;
    logic [3:0]      awcache;
    logic [3:0]      awqos;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic [IW-1:0]   bid;
    logic            bvalid;
    logic            bready;

    modport master (
        output awaddr, awuser, awlen, awsize, awid, awburst, awlock, awcache, awqos, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bid, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awuser, awlen, awsize, awid, awburst, awlock, awcache, awqos, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bid, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi4_wr_arbiter.sv
// Two-to-one AXI4 write arbiter: round-robin grant per whole burst (AW then W
// through WLAST); B responses are steered back by the MSB of the returned ID.
module axi4_wr_arbiter #(
    parameter int DW = 512,
    parameter int AW = 64,
    parameter int IW = 4
) (
    input  logic               clk,
    input  logic               resetn,
    axi4_wr_arbiter_if.slave   s0,
    axi4_wr_arbiter_if.slave   s1,
    axi4_wr_arbiter_if.master  dst
);
    typedef enum logic [1:0] {ARB_IDLE, ARB_AW, ARB_W} state_t;

    state_t          state;
    logic            sel;
    logic            last;
    logic            in_aw;
    logic            in_w;
    logic [AW-1:0]   awaddr_sel;
    logic [DW-1:0]   wdata_sel;

    // Handshakes are gated by resetn so nothing is offered while reset is held.
    assign in_aw = resetn && (state == ARB_AW);
    assign in_w  = resetn && (state == ARB_W);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ARB_IDLE;
            sel   <= 1'b0;
            last  <= 1'b1;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (s0.awvalid || s1.awvalid) begin
                        // On a tie the source that did not win last time goes first.
                        if (s0.awvalid && s1.awvalid) sel <= ~last;
                        else                          sel <= s1.awvalid;
                        state <= ARB_AW;
                    end
                end
                ARB_AW: begin
                    if (dst.awvalid && dst.awready) begin
                        last  <= sel;
                        state <= ARB_W;
                    end
                end
                ARB_W: begin
                    if (dst.wvalid && dst.wready && dst.wlast) state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // AW path
    assign awaddr_sel  = sel ? s1.awaddr : s0.awaddr;
    assign dst.awaddr  = awaddr_sel;
    assign dst.awuser  = sel ? s1.awuser  : s0.awuser;
    assign dst.awlen   = sel ? s1.awlen   : s0.awlen;
    assign dst.awsize  = sel ? s1.awsize  : s0.awsize;
    assign dst.awid    = {sel, (sel ? s1.awid : s0.awid)};
    assign dst.awburst = sel ? s1.awburst : s0.awburst;
    assign dst.awlock  = sel ? s1.awlock  : s0.awlock;
    assign dst.awcache = sel ? s1.awcache : s0.awcache;
    assign dst.awqos   = sel ? s1.awqos   : s0.awqos;
    assign dst.awprot  = sel ? s1.awprot  : s0.awprot;
    assign dst.awvalid = in_aw && (sel ? s1.awvalid : s0.awvalid);
    assign s0.awready  = in_aw && !sel && dst.awready;
    assign s1.awready  = in_aw &&  sel && dst.awready;

    // W path
    assign wdata_sel   = sel ? s1.wdata : s0.wdata;
    assign dst.wdata   = wdata_sel;
    assign dst.wstrb   = sel ? s1.wstrb : s0.wstrb;
    assign dst.wlast   = sel ? s1.wlast : s0.wlast;
    assign dst.wvalid  = in_w && (sel ? s1.wvalid : s0.wvalid);
    assign s0.wready   = in_w && !sel && dst.wready;
    assign s1.wready   = in_w &&  sel && dst.wready;

    // B path is stateless: the ID MSB names the originating master.
    assign s0.bvalid   = dst.bvalid && !dst.bid[IW];
    assign s1.bvalid   = dst.bvalid &&  dst.bid[IW];
    assign s0.bid      = dst.bid[IW-1:0];
    assign s1.bid      = dst.bid[IW-1:0];
    assign s0.bresp    = dst.bresp;
    assign s1.bresp    = dst.bresp;
    assign dst.bready  = dst.bid[IW] ? s1.bready : s0.bready;
endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Bench for axi4_wr_arbiter: random bursts from two masters, expected DST
// AW/W streams built from the round-robin rule and compared beat by beat.
module tb_axi4_wr_arbiter;
    localparam int DW  = 512;
    localparam int AW  = 64;
    localparam int IW  = 4;
    localparam int AWW = IW + 1 + AW + 1 + 8 + 3 + 2 + 1 + 4 + 4 + 3;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic          user;
        logic [7:0]    len;
        logic [31:0]   seed;
    } burst_t;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        logic            last;
    } beat_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    axi4_wr_arbiter_if #(.DW(DW), .AW(AW), .IW(IW))   src [2] ();
    axi4_wr_arbiter_if #(.DW(DW), .AW(AW), .IW(IW+1)) dst ();

    axi4_wr_arbiter #(.DW(DW), .AW(AW), .IW(IW)) dut (
        .clk(clk), .resetn(resetn), .s0(src[0]), .s1(src[1]), .dst(dst)
    );

    logic [AW-1:0]   m_awaddr [2];
    logic            m_awuser [2];
    logic [7:0]      m_awlen [2];
    logic [2:0]      m_awsize [2];
    logic [IW-1:0]   m_awid [2];
    logic [1:0]      m_awburst [2];
    logic            m_awlock [2];
    logic [3:0]      m_awcache [2];
    logic [3:0]      m_awqos [2];
    logic [2:0]      m_awprot [2];
    logic            m_awvalid [2];
    logic [DW-1:0]   m_wdata [2];
    logic [DW/8-1:0] m_wstrb [2];
    logic            m_wlast [2];
    logic            m_wvalid [2];
    logic            m_bready [2];
    logic            m_awready [2];
    logic            m_wready [2];

    for (genvar g = 0; g < 2; g++) begin : g_src
        assign src[g].awaddr  = m_awaddr[g];
        assign src[g].awuser  = m_awuser[g];
        assign src[g].awlen   = m_awlen[g];
        assign src[g].awsize  = m_awsize[g];
        assign src[g].awid    = m_awid[g];
        assign src[g].awburst = m_awburst[g];
        assign src[g].awlock  = m_awlock[g];
        assign src[g].awcache = m_awcache[g];
        assign src[g].awqos   = m_awqos[g];
        assign src[g].awprot  = m_awprot[g];
        assign src[g].awvalid = m_awvalid[g];
        assign src[g].wdata   = m_wdata[g];
        assign src[g].wstrb   = m_wstrb[g];
        assign src[g].wlast   = m_wlast[g];
        assign src[g].wvalid  = m_wvalid[g];
        assign src[g].bready  = m_bready[g];
        assign m_awready[g]   = src[g].awready;
        assign m_wready[g]    = src[g].wready;
    end

    logic          d_awready, d_wready, d_bvalid;
    logic [1:0]    d_bresp;
    logic [IW:0]   d_bid;
    assign dst.awready = d_awready;
    assign dst.wready  = d_wready;
    assign dst.bvalid  = d_bvalid;
    assign dst.bresp   = d_bresp;
    assign dst.bid     = d_bid;

    int cmp = 0;
    int err = 0;
    int s1_rdy = 0;

    logic [AWW-1:0] mon_aw [$];
    logic [AWW-1:0] exp_aw [$];
    beat_t          mon_w [$];
    beat_t          exp_w [$];

    always @(negedge clk) begin
        if (dst.awvalid && dst.awready)
            mon_aw.push_back({dst.awid, dst.awaddr, dst.awuser, dst.awlen, dst.awsize, dst.awburst,
                              dst.awlock, dst.awcache, dst.awqos, dst.awprot});
        if (dst.wvalid && dst.wready) mon_w.push_back({dst.wdata, dst.wstrb, dst.wlast});
        if (m_awready[1] || m_wready[1]) s1_rdy++;
    end

    function automatic logic [DW-1:0] bdata(logic [31:0] s, int k);
        return {16{s ^ (32'(k) * 32'h9E37_79B9)}};
    endfunction

    function automatic logic [DW/8-1:0] bstrb(logic [31:0] s, int k);
        return {2{s + 32'(k)}};
    endfunction

    function automatic logic [AWW-1:0] awword(int m, burst_t b);
        return {1'(m), b.id, b.addr, b.user, b.len, b.seed[2:0], b.seed[4:3], b.seed[5],
                b.seed[9:6], b.seed[13:10], b.seed[16:14]};
    endfunction

    function automatic burst_t rand_burst(int len, logic user);
        burst_t b;
        b.id   = IW'($urandom);
        b.addr = {$urandom, $urandom};
        b.user = user;
        b.len  = 8'(len);
        b.seed = $urandom;
        return b;
    endfunction

    // Expected DST traffic for one granted burst: its AW, then every beat in order.
    task automatic expect_burst(input int m, input burst_t b);
        exp_aw.push_back(awword(m, b));
        for (int k = 0; k <= int'(b.len); k++)
            exp_w.push_back({bdata(b.seed, k), bstrb(b.seed, k), k == int'(b.len)});
    endtask

    task automatic run_burst(input int m, input burst_t b);
        int  k = 0;
        int  n = 0;
        bit  aw_hs, w_hs;
        @(posedge clk); #1;
        m_awid[m] = b.id;  m_awaddr[m] = b.addr; m_awuser[m] = b.user; m_awlen[m] = b.len;
        m_awsize[m] = b.seed[2:0]; m_awburst[m] = b.seed[4:3]; m_awlock[m] = b.seed[5];
        m_awcache[m] = b.seed[9:6]; m_awqos[m] = b.seed[13:10]; m_awprot[m] = b.seed[16:14];
        m_awvalid[m] = 1'b1;
        m_wdata[m] = bdata(b.seed, 0); m_wstrb[m] = bstrb(b.seed, 0);
        m_wlast[m] = (b.len == 8'd0); m_wvalid[m] = 1'b1;
        while ((m_awvalid[m] || m_wvalid[m]) && n < 300) begin
            @(negedge clk);
            aw_hs = m_awvalid[m] && m_awready[m];
            w_hs  = m_wvalid[m] && m_wready[m];
            @(posedge clk); #1;
            n++;
            if (aw_hs) m_awvalid[m] = 1'b0;
            if (w_hs) begin
                k++;
                if (k > int'(b.len)) m_wvalid[m] = 1'b0;
                else begin
                    m_wdata[m] = bdata(b.seed, k); m_wstrb[m] = bstrb(b.seed, k);
                    m_wlast[m] = (k == int'(b.len));
                end
            end
        end
        if (n >= 300) begin
            cmp++; err++;
            $display("FAIL burst_timeout master=%0d beats_done=%0d required=%0d", m, k, int'(b.len) + 1);
            m_awvalid[m] = 1'b0; m_wvalid[m] = 1'b0;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_awvalid[i] = 1'b0; m_wvalid[i] = 1'b0; m_wlast[i] = 1'b0; m_bready[i] = 1'b0;
        end
        d_awready = 1'b1; d_wready = 1'b1; d_bvalid = 1'b0; d_bresp = 2'd0; d_bid = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        mon_aw.delete(); mon_w.delete(); exp_aw.delete(); exp_w.delete();
        s1_rdy = 0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_awvalid[i] = 1'b1; m_wvalid[i] = 1'b1; m_wlast[i] = 1'b1; m_bready[i] = 1'b1;
            m_awid[i] = '0; m_awaddr[i] = '0; m_awuser[i] = 1'b0; m_awlen[i] = '0; m_awsize[i] = '0;
            m_awburst[i] = '0; m_awlock[i] = 1'b0; m_awcache[i] = '0; m_awqos[i] = '0; m_awprot[i] = '0;
            m_wdata[i] = '0; m_wstrb[i] = '0;
        end
        d_awready = 1'b1; d_wready = 1'b1; d_bvalid = 1'b1; d_bresp = 2'b10; d_bid = 5'b1_0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp++;
        if ({dst.awvalid, dst.wvalid, m_awready[0], m_awready[1], m_wready[0], m_wready[1]} !== 6'b0)
            begin err++; $display("FAIL reset_outputs got=%b required=000000",
                {dst.awvalid, dst.wvalid, m_awready[0], m_awready[1], m_wready[0], m_wready[1]}); end
        cmp++;
        if ({src[0].bvalid, src[1].bvalid, src[1].bid} !== 6'b01_0001)
            begin err++; $display("FAIL reset_b_path got=%b required=010001",
                {src[0].bvalid, src[1].bvalid, src[1].bid}); end
        do_reset();
    endtask

    task automatic test_single_s0();
        burst_t b;
        do_reset();
        b = rand_burst(3, 1'b0);
        expect_burst(0, b);
        fork
            run_burst(0, b);
            begin
                @(posedge clk); @(negedge clk);
                cmp++;
                if (dst.awvalid !== 1'b0) begin err++; $display("FAIL latency_n got=%b required=0", dst.awvalid); end
                @(negedge clk);
                cmp++;
                if ({dst.awvalid, dst.awid} !== {1'b1, 1'b0, b.id})
                    begin err++; $display("FAIL latency_n1 got=%b/%h required=1/%h", dst.awvalid, dst.awid, {1'b0, b.id}); end
            end
        join
        @(negedge clk);
        cmp++;
        if ({dst.wvalid, m_wready[0], dst.awvalid} !== 3'b000)
            begin err++; $display("FAIL idle_after_wlast got=%b required=000", {dst.wvalid, m_wready[0], dst.awvalid}); end
        cmp++;
        if (s1_rdy !== 0) begin err++; $display("FAIL s1_ready_idle got=%0d required=0", s1_rdy); end
        cmp++;
        if (mon_aw.size() !== exp_aw.size() || mon_w.size() !== exp_w.size())
            begin err++; $display("FAIL single_counts got=%0d/%0d required=%0d/%0d", mon_aw.size(), mon_w.size(), exp_aw.size(), exp_w.size()); end
        for (int i = 0; i < mon_aw.size() && i < exp_aw.size(); i++) begin
            cmp++;
            if (mon_aw[i] !== exp_aw[i]) begin err++; $display("FAIL single_aw%0d got=%h required=%h", i, mon_aw[i], exp_aw[i]); end
        end
        for (int i = 0; i < mon_w.size() && i < exp_w.size(); i++) begin
            cmp++;
            if (mon_w[i] !== exp_w[i]) begin err++; $display("FAIL single_w%0d got=%h/%b required=%h/%b", i,
                mon_w[i].data[31:0], mon_w[i].last, exp_w[i].data[31:0], exp_w[i].last); end
        end
    endtask

    task automatic test_back_to_back();
        burst_t b0 [3];
        burst_t b1 [3];
        int p0 = 3, p1 = 3, k0 = 0, k1 = 0, lastg = 1, g;
        do_reset();
        for (int i = 0; i < 3; i++) begin b0[i] = rand_burst(0, 1'(i)); b1[i] = rand_burst(0, 1'(i + 1)); end
        // Round robin with both masters always pending: the non-last source wins.
        while (p0 > 0 || p1 > 0) begin
            g = (p0 > 0 && p1 > 0) ? 1 - lastg : (p0 > 0 ? 0 : 1);
            if (g == 0) begin expect_burst(0, b0[k0]); k0++; p0--; end
            else        begin expect_burst(1, b1[k1]); k1++; p1--; end
            lastg = g;
        end
        fork
            for (int i = 0; i < 3; i++) run_burst(0, b0[i]);
            for (int j = 0; j < 3; j++) run_burst(1, b1[j]);
        join
        cmp++;
        if (mon_aw.size() !== 6 || mon_w.size() !== 6)
            begin err++; $display("FAIL b2b_counts got=%0d/%0d required=6/6", mon_aw.size(), mon_w.size()); end
        for (int i = 0; i < mon_aw.size() && i < exp_aw.size(); i++) begin
            cmp++;
            if (mon_aw[i] !== exp_aw[i]) begin err++; $display("FAIL b2b_aw%0d got_src=%b required_src=%b got=%h required=%h", i,
                mon_aw[i][AWW-1], exp_aw[i][AWW-1], mon_aw[i], exp_aw[i]); end
        end
        for (int i = 0; i < mon_w.size() && i < exp_w.size(); i++) begin
            cmp++;
            if (mon_w[i] !== exp_w[i]) begin err++; $display("FAIL b2b_w%0d got=%h required=%h", i,
                mon_w[i].data[31:0], exp_w[i].data[31:0]); end
        end
    endtask

    task automatic test_aw_stall();
        burst_t b0, b1;
        do_reset();
        d_awready = 1'b0;
        b1 = rand_burst(2, 1'b1);
        b0 = rand_burst(1, 1'b0);
        expect_burst(1, b1);
        expect_burst(0, b0);
        fork
            run_burst(1, b1);
            begin repeat (3) @(posedge clk); run_burst(0, b0); end
            begin
                @(posedge clk); @(posedge clk);
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    cmp++;
                    if ({dst.awvalid, dst.awuser, dst.awid[IW], m_awready[0], m_wready[0], dst.wvalid} !== 6'b111000)
                        begin err++; $display("FAIL stall_cycle%0d got=%b required=111000", i,
                            {dst.awvalid, dst.awuser, dst.awid[IW], m_awready[0], m_wready[0], dst.wvalid}); end
                end
                @(posedge clk); #1 d_awready = 1'b1;
            end
        join
        cmp++;
        if (mon_aw.size() !== 2 || mon_w.size() !== 5)
            begin err++; $display("FAIL stall_counts got=%0d/%0d required=2/5", mon_aw.size(), mon_w.size()); end
        for (int i = 0; i < mon_aw.size() && i < exp_aw.size(); i++) begin
            cmp++;
            if (mon_aw[i] !== exp_aw[i]) begin err++; $display("FAIL stall_aw%0d got=%h required=%h", i, mon_aw[i], exp_aw[i]); end
        end
        for (int i = 0; i < mon_w.size() && i < exp_w.size(); i++) begin
            cmp++;
            if (mon_w[i] !== exp_w[i]) begin err++; $display("FAIL stall_w%0d got=%h required=%h", i,
                mon_w[i].data[31:0], exp_w[i].data[31:0]); end
        end
    endtask

    task automatic test_w_backpressure();
        burst_t b;
        bit done = 1'b0;
        do_reset();
        b = rand_burst(15, 1'($urandom));
        expect_burst(0, b);
        fork
            begin run_burst(0, b); done = 1'b1; end
            while (!done) begin @(posedge clk); #1 d_wready = 1'($urandom_range(0, 1)); end
        join
        d_wready = 1'b1;
        cmp++;
        if (mon_w.size() !== 16) begin err++; $display("FAIL bp_beats got=%0d required=16", mon_w.size()); end
        for (int i = 0; i < mon_w.size() && i < exp_w.size(); i++) begin
            cmp++;
            if (mon_w[i] !== exp_w[i]) begin err++; $display("FAIL bp_w%0d got=%h/%h/%b required=%h/%h/%b", i,
                mon_w[i].data[31:0], mon_w[i].strb[15:0], mon_w[i].last,
                exp_w[i].data[31:0], exp_w[i].strb[15:0], exp_w[i].last); end
        end
        @(negedge clk);
        cmp++;
        if (m_wready[0] !== 1'b0) begin err++; $display("FAIL bp_idle got=%b required=0", m_wready[0]); end
    endtask

    task automatic test_b_route();
        logic [IW:0] bids [2];
        logic        bsel, bv, br0, br1;
        logic [1:0]  resp;
        logic [8:0]  got, want;
        do_reset();
        bids[0] = 5'b1_0011;
        bids[1] = 5'b0_0111;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            d_bid = (i < 2) ? bids[i] : (IW+1)'($urandom);
            bv    = (i < 2) ? 1'b1 : 1'($urandom);
            resp  = 2'($urandom);
            br0   = 1'($urandom); br1 = 1'($urandom);
            d_bvalid = bv; d_bresp = resp; m_bready[0] = br0; m_bready[1] = br1;
            bsel = d_bid[IW];
            @(negedge clk);
            want = {bv && !bsel, bv && bsel, d_bid[IW-1:0], resp, bsel ? br1 : br0};
            got  = {src[0].bvalid, src[1].bvalid, bsel ? src[1].bid : src[0].bid,
                    bsel ? src[1].bresp : src[0].bresp, dst.bready};
            cmp++;
            if (got !== want) begin err++; $display("FAIL b_route%0d bid=%b got=%b required=%b", i, d_bid, got, want); end
        end
        d_bvalid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        burst_t b0, b1;
        int n = 0;
        do_reset();
        d_wready = 1'b0;
        @(posedge clk); #1;
        m_awid[0] = 4'h9; m_awvalid[0] = 1'b1; m_awlen[0] = 8'd7;
        m_wvalid[0] = 1'b1; m_wlast[0] = 1'b0;
        m_awvalid[1] = 1'b1; m_wvalid[1] = 1'b1;
        do begin @(negedge clk); n++; end while (!dst.wvalid && n < 10);
        cmp++;
        if (dst.wvalid !== 1'b1) begin err++; $display("FAIL mid_reach_w got=%b required=1", dst.wvalid); end
        @(posedge clk); #1;
        m_awvalid[0] = 1'b0; d_wready = 1'b1; resetn = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            cmp++;
            if ({dst.awvalid, dst.wvalid, m_awready[0], m_awready[1], m_wready[0], m_wready[1]} !== 6'b0)
                begin err++; $display("FAIL mid_reset_cycle%0d got=%b required=000000", c,
                    {dst.awvalid, dst.wvalid, m_awready[0], m_awready[1], m_wready[0], m_wready[1]}); end
            @(posedge clk); #1;
        end
        do_reset();
        b0 = rand_burst(0, 1'b0);
        b1 = rand_burst(0, 1'b1);
        expect_burst(0, b0);
        expect_burst(1, b1);
        fork
            run_burst(0, b0);
            run_burst(1, b1);
        join
        cmp++;
        if (mon_aw.size() !== 2) begin err++; $display("FAIL tie_count got=%0d required=2", mon_aw.size()); end
        for (int i = 0; i < mon_aw.size() && i < exp_aw.size(); i++) begin
            cmp++;
            if (mon_aw[i] !== exp_aw[i]) begin err++; $display("FAIL tie_aw%0d got_src=%b required_src=%b", i,
                mon_aw[i][AWW-1], exp_aw[i][AWW-1]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_s0();
        test_back_to_back();
        test_aw_stall();
        test_w_backpressure();
        test_b_route();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule

// File: doc/axi4_wr_arbiter.md
# axi4_wr_arbiter

Two-to-one AXI4 write-channel arbiter that shares one downstream AXI4 write port (typically the input of the memory-fence block) between two write masters. It grants round-robin on whole bursts: the AW request and every W beat through WLAST. It forwards AWUSER unchanged so fence requests from either master pass through intact. Write responses route back to the originating master by a requester tag carried in the MSB of the outgoing ID.

## Interface
- DW, 512, data width in bits
- AW, 64, address width
- IW, 4, ID width of each source master; the outgoing ID is IW+1 bits
- clk  input  1  sole clock
- resetn  input  1  synchronous, active-low reset
- S0_AXI_AW{ADDR,USER,LEN,SIZE,ID,BURST,LOCK,CACHE,QOS,PROT,VALID}  input  AW/1/8/3/IW/2/1/4/4/3/1  master-0 write address
- S0_AXI_AWREADY  output  1  master-0 AW ready
- S0_AXI_W{DATA,STRB,LAST,VALID}  input  DW/DW/8/1/1  master-0 write data
- S0_AXI_WREADY  output  1  master-0 W ready
- S0_AXI_B{RESP,ID,VALID}  output  2/IW/1  master-0 write response
- S0_AXI_BREADY  input  1  master-0 B ready
- S1_AXI_*  same directions and widths as S0  master-1 write channels
- DST_AXI_AW{ADDR,USER,LEN,SIZE,BURST,LOCK,CACHE,QOS,PROT,VALID}  output  as source  granted AW
- DST_AXI_AWID  output  IW+1  {source index, source AWID}
- DST_AXI_AWREADY  input  1  downstream AW ready
- DST_AXI_W{DATA,STRB,LAST,VALID}  output  DW/DW/8/1/1  granted W
- DST_AXI_WREADY  input  1  downstream W ready
- DST_AXI_B{RESP,VALID}  input  2/1  downstream response
- DST_AXI_BID  input  IW+1  response ID; MSB selects the destination master
- DST_AXI_BREADY  output  1  downstream B ready

## Operation
- FSM states:
  - ARB_IDLE: no grant.
  - ARB_AW: the granted master's AW is forwarded.
  - ARB_W: the granted master's W beats are forwarded.
- Grant register `sel`, 1 bit; `last` register records the most recently granted source.
- ARB_IDLE:
  - If exactly one SRC AWVALID is high, grant that source.
  - If both are high, grant the source that is not `last`.
  - On a grant, load `sel` and move to ARB_AW.
- ARB_AW:
  - DST_AXI_AWVALID = Ssel AWVALID; Ssel AWREADY = DST_AXI_AWREADY.
  - All other AW fields, including AWUSER, are muxed from Ssel. AWID = {sel, Ssel AWID}.
  - On the DST AW handshake: `last` <= sel; move to ARB_W.
- ARB_W:
  - DST W signals are muxed from Ssel; Ssel WREADY = DST_AXI_WREADY.
  - On a W handshake with WLAST = 1, move to ARB_IDLE.
  - Beats are not counted; WLAST alone terminates the burst.
- The ungranted master sees AWREADY = 0 and WREADY = 0.
- Outside ARB_W, DST_AXI_WVALID = 0 and both WREADY outputs are 0.
  - W data presented before its AW is granted waits; AXI permits this.
- B channel is purely combinational and independent of the FSM:
  - DST_AXI_BID[IW] selects the master; that master gets BVALID = DST BVALID, BID = DST_AXI_BID[IW-1:0], BRESP = DST BRESP.
  - The other master's BVALID = 0.
  - DST_AXI_BREADY = the selected master's BREADY.
- AWUSER (fence) requests get no special treatment; the downstream fence block may stall AWREADY for any duration, and the grant is held throughout.

## Timing
- Reset: FSM = ARB_IDLE, sel = 0, last = 1, so master 0 wins the first tie.
- Outputs during and after reset:
  - DST_AXI_AWVALID, DST_AXI_WVALID, S0/S1 AWREADY and S0/S1 WREADY are 0.
  - B outputs follow the combinational path.
- Arbitration latency: SRC AWVALID rising in ARB_IDLE at cycle N gives DST_AXI_AWVALID high at cycle N+1.
- Minimum burst overhead: one idle cycle between the WLAST handshake and the next AW grant.
  - A single-beat burst (AWLEN = 0) therefore occupies at least 3 cycles: IDLE, AW, W.
- Each master must hold AWVALID and its fields stable until its handshake, per AXI.
- AWVALID deasserting while in ARB_AW is a protocol violation; behaviour is undefined.
- Reset asserted mid-burst: the FSM returns to ARB_IDLE on the next edge, and all VALID/READY outputs driven by the FSM are 0 while resetn = 0.
- Simultaneous events: a B response and an AW/W grant are independent and may occur in the same cycle.

## Test plan
- Reset, then only S0 issues AWLEN = 3 → DST AWVALID at cycle +1 with AWID = {0, S0 ID}; 4 W beats pass; FSM returns to IDLE after WLAST; S1 READYs stay 0.
- Both masters request AWLEN = 0 bursts continuously for 6 grants → grant order S0, S1, S0, S1, S0, S1; no W beat from the ungranted master reaches DST.
- Downstream holds AWREADY = 0 for 20 cycles during an S1 request with AWUSER = 1 → DST AWUSER = 1 and the grant is held; S0 AWREADY stays 0 throughout; the burst completes after AWREADY rises.
- Random WREADY backpressure on an AWLEN = 15 burst → exactly 16 beats forwarded, data and strobes match, IDLE reached only after the WLAST handshake.
- DST B responses with BID = 5'b1_0011, then 5'b0_0111 → S1 gets BID = 3, then S0 gets BID = 7; DST BREADY tracks the selected master's BREADY.
- Assert resetn = 0 mid-W-burst → all FSM-driven VALID/READY outputs are 0 the next cycle; after release, the first grant on a tie goes to S0.
